// File: rtl/light_sequence_monitor.sv
// Traffic-light sequence monitor: decodes lamp drives, checks phase order and dwell times, latches the first fault.
// Optional macro LIGHT_MON_CYCLE_COUNT_EN enables the completed-cycle counter.
module light_sequence_monitor #(
  parameter int MIN_GREEN  = 4,
  parameter int YELLOW_LEN = 2,
  parameter int MAX_DWELL  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EW_RED,
  input  logic        EW_YELLOW,
  input  logic        EW_GREEN,
  input  logic        NS_RED,
  input  logic        NS_YELLOW,
  input  logic        NS_GREEN,
  input  logic        clr,
  output logic [2:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {
    P_INIT    = 3'd0,
    P_NS_G    = 3'd1,
    P_NS_Y    = 3'd2,
    P_EW_G    = 3'd3,
    P_EW_Y    = 3'd4,
    P_ALL_RED = 3'd5,
    P_ILLEGAL = 3'd7
  } phase_t;

  localparam logic [15:0] MIN_GREEN_W  = 16'(MIN_GREEN);
  localparam logic [15:0] YELLOW_LEN_W = 16'(YELLOW_LEN);
  localparam logic [15:0] MAX_DWELL_W  = 16'(MAX_DWELL);

  // Lamp vector packed as {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN}
  function automatic phase_t decode(input logic [5:0] v);
    case (v)
      6'b001_100: decode = P_NS_G;
      6'b010_100: decode = P_NS_Y;
      6'b100_001: decode = P_EW_G;
      6'b100_010: decode = P_EW_Y;
      6'b100_100: decode = P_ALL_RED;
      default:    decode = P_ILLEGAL;
    endcase
  endfunction

  function automatic logic legal_step(input phase_t from, input phase_t to);
    case (from)
      P_NS_G:    legal_step = (to == P_NS_Y);
      P_NS_Y:    legal_step = (to == P_EW_G) || (to == P_ALL_RED);
      P_EW_G:    legal_step = (to == P_EW_Y);
      P_EW_Y:    legal_step = (to == P_NS_G) || (to == P_ALL_RED);
      P_ALL_RED: legal_step = (to == P_NS_G) || (to == P_EW_G);
      default:   legal_step = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [5:0]  lamp_p0;
  logic        primed;
  phase_t      cur;
  phase_t      track, track_next;
  logic [15:0] dwell, dwell_next;
  logic        changed;
  logic [2:0]  det_code;

  // Stage 0: lamp register; primed marks that it holds a real sample since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_p0 <= '0;
      primed  <= 1'b0;
    end else begin
      lamp_p0 <= {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN};
      primed  <= 1'b1;
    end
  end

  assign cur = decode(lamp_p0);

  // Stage 1: tracked phase and its dwell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      track <= P_INIT;
      dwell <= '0;
    end else if (primed) begin
      track <= track_next;
      dwell <= dwell_next;
    end
  end

  always_comb begin
    track_next = cur;
    changed    = (cur != track);
    dwell_next = changed ? 16'd1 : sat_inc(dwell);
  end

  always_comb begin
    phase = primed ? cur : P_INIT;
  end

  // Fault detection; INIT and ILLEGAL as the previous phase skip order/timing checks (resync)
  logic from_legal, leaving, f_illegal, f_trans, f_short, f_yellow, f_stuck;

  always_comb begin
    from_legal = (track == P_NS_G) || (track == P_NS_Y) || (track == P_EW_G) ||
                 (track == P_EW_Y) || (track == P_ALL_RED);
    leaving    = primed && changed && from_legal;
    f_illegal  = primed && (cur == P_ILLEGAL);
    f_trans    = leaving && (cur != P_ILLEGAL) && !legal_step(track, cur);
    f_short    = leaving && ((track == P_NS_G) || (track == P_EW_G)) && (dwell < MIN_GREEN_W);
    f_yellow   = leaving && ((track == P_NS_Y) || (track == P_EW_Y)) && (dwell != YELLOW_LEN_W);
    // Fires only on the cycle the dwell first reaches the limit
    f_stuck    = primed && (dwell_next == MAX_DWELL_W) && (changed || (dwell != dwell_next));
    det_code   = 3'd0;
    if (f_illegal)     det_code = 3'd1;
    else if (f_trans)  det_code = 3'd2;
    else if (f_short)  det_code = 3'd3;
    else if (f_yellow) det_code = 3'd4;
    else if (f_stuck)  det_code = 3'd5;
  end

  // Stage 2: sticky fault; a fault arriving with clr is latched, not cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else if (clr) begin
      fault      <= (det_code != 3'd0);
      fault_code <= det_code;
    end else if (!fault && (det_code != 3'd0)) begin
      fault      <= 1'b1;
      fault_code <= det_code;
    end
  end

`ifdef LIGHT_MON_CYCLE_COUNT_EN
  logic [15:0] count_p1;
  logic        cycle_entry;

  assign cycle_entry = primed && (cur == P_NS_G) && ((track == P_EW_Y) || (track == P_ALL_RED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p1 <= '0;
    end else if (cycle_entry) begin
      count_p1 <= sat_inc(count_p1);
    end
  end

  assign cycle_count = count_p1;
`else
  assign cycle_count = 16'd0;
`endif

endmodule
